// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned c_NUM_DATA_BITS        = 8;
  localparam int unsigned c_DEF_CLK_PER_HALF_BIT = 435;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the serial line, resets to idle (1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  assign o_sync = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with valid/ack hand-off, framing-error,
//               break handling and sticky overrun flag.
//               Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = c_DEF_CLK_PER_HALF_BIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       ferr,
  output logic       overrun
);

  localparam int unsigned CW  = $clog2(2 * CLK_PER_HALF_BIT) + 1;
  localparam int unsigned BCW = $clog2(c_NUM_DATA_BITS);

  localparam logic [CW-1:0] c_HALF_END = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] c_FULL_END = CW'(2 * CLK_PER_HALF_BIT - 1);

  logic                       w_rxs;
  logic                       r_rxs_d;
  rx_state_e                  r_state;
  logic [CW-1:0]              r_cnt;
  logic [BCW-1:0]             r_bitcnt;
  logic [c_NUM_DATA_BITS-1:0] r_shift;
  logic                       r_deliver;
  logic                       r_stop_err;

  logic w_in_frame;
  logic w_period_end;
  logic w_centre;
  logic w_act;
  logic w_sample;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (rxd),
    .o_sync  (w_rxs)
  );

  assign w_in_frame   = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);
  assign w_period_end = (r_state == ST_START) ? (r_cnt == c_HALF_END) : (r_cnt == c_FULL_END);
  assign w_centre     = w_in_frame && w_period_end;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] c_HALF_PRE = CW'(CLK_PER_HALF_BIT - 2);
  localparam logic [CW-1:0] c_FULL_PRE = CW'(2 * CLK_PER_HALF_BIT - 2);

  logic w_pre;
  logic r_pre;
  logic r_mid;
  logic r_act;

  assign w_pre = w_in_frame &&
                 ((r_state == ST_START) ? (r_cnt == c_HALF_PRE) : (r_cnt == c_FULL_PRE));

  // Votes are gathered at centre-1 and centre; the decision is taken at centre+1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre <= 1'b1;
      r_mid <= 1'b1;
      r_act <= 1'b0;
    end else begin
      if (w_pre) begin
        r_pre <= w_rxs;
      end
      if (w_centre) begin
        r_mid <= w_rxs;
      end
      r_act <= w_centre;
    end
  end

  assign w_act    = r_act;
  assign w_sample = maj3(r_pre, r_mid, w_rxs);
`else
  assign w_act    = w_centre;
  assign w_sample = w_rxs;
`endif

  // The bit timer restarts at every centre so that sampling points stay
  // exactly one bit apart regardless of when the decision is taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_rxs_d    <= 1'b1;
      r_cnt      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_deliver  <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_rxs_d   <= w_rxs;
      r_deliver <= 1'b0;

      if (w_in_frame) begin
        r_cnt <= w_period_end ? '0 : r_cnt + CW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_state  <= ST_START;
            r_cnt    <= '0;
            r_bitcnt <= '0;
          end
        end
        ST_START: begin
          if (w_act) begin
            r_state <= w_sample ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_act) begin
            r_shift  <= {w_sample, r_shift[c_NUM_DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt + BCW'(1);
            if (r_bitcnt == BCW'(c_NUM_DATA_BITS - 1)) begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (w_act) begin
            r_deliver  <= 1'b1;
            r_stop_err <= ~w_sample;
            r_state    <= w_sample ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (w_rxs) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Consumer hand-off: a same-cycle ack frees the holding register for the new byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata    <= '0;
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
      overrun  <= 1'b0;
    end else if (r_deliver) begin
      if (!rx_valid) begin
        rdata    <= r_shift;
        ferr     <= r_stop_err;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rdata    <= r_shift;
        ferr     <= r_stop_err;
        overrun  <= 1'b0;
      end else begin
        overrun  <= 1'b1;
      end
    end else if (rx_valid && rx_ack) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed scoreboard bench for uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int H   = 8;
  localparam int BIT = 2 * H;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_LAT = 1;
`else
  localparam int MAJ_LAT = 0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       rxd    = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       ferr;
  logic       overrun;

  exp_t q[$];
  exp_t m_e;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   ack_at   = -1;
  int   n_pop    = 0;
  bit   auto_ack = 1'b0;
  bit   m_do_ack;

  uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rdata    (rdata),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .ferr     (ferr),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; drives start, 8 data bits LSB first, then stop.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_clks);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (stop_clks) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic ov);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.ov = ov;
    q.push_back(e);
  endtask

  initial begin
    fork
      // Consumer and monitor: compares the holding register whenever it acks.
      forever begin
        @(negedge clk);
        m_do_ack = (auto_ack && rx_valid && !rx_ack) || (cyc == ack_at);
        if (m_do_ack && rx_valid) begin
          n_vec++;
          n_pop++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_byte#%0d: got rdata=%02h ferr=%0b ovr=%0b, required none",
                     n_pop, rdata, ferr, overrun);
          end else begin
            m_e = q.pop_front();
            if ({rdata, ferr, overrun} !== {m_e.d, m_e.fe, m_e.ov}) begin
              n_err++;
              $display("FAIL byte#%0d: got rdata=%02h ferr=%0b ovr=%0b, required rdata=%02h ferr=%0b ovr=%0b",
                       n_pop, rdata, ferr, overrun, m_e.d, m_e.fe, m_e.ov);
            end
          end
        end
        rx_ack = m_do_ack;
      end
    join_none

    #12;
    chk("reset_rdata", int'(rdata), 0);
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_ferr", int'(ferr), 0);
    chk("reset_overrun", int'(overrun), 0);
    @(negedge clk);
    rstn = 1'b1;
    auto_ack = 1'b1;
    idle(BIT);

    // Two ordinary frames
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, BIT);
    idle(BIT);
    push(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, BIT);
    idle(BIT);

    // Short glitch must be rejected, then a clean frame
    rxd = 1'b0;
    repeat (H / 2) @(negedge clk);
    idle(4 * BIT);
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, BIT);
    idle(BIT);

    // Framing error followed by a held-low break
    push(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 3 * BIT);
    idle(BIT);
    push(8'h0F, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, BIT);
    idle(BIT);

    // Overrun, then an ack coinciding with the next delivery
    auto_ack = 1'b0;
    send_frame(8'h11, 1'b1, BIT);
    idle(BIT);
    send_frame(8'h22, 1'b1, BIT);
    idle(BIT);
    push(8'h11, 1'b0, 1'b1);
    push(8'h33, 1'b0, 1'b0);
    ack_at = cyc + 19 * H + 3 + MAJ_LAT;
    send_frame(8'h33, 1'b1, BIT);
    idle(BIT);
    ack_at = -1;
    auto_ack = 1'b1;
    idle(BIT);

    // Back-to-back frames with 0.9-bit stop bits
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0, 1'b0);
      send_frame(8'(i), 1'b1, (BIT * 9) / 10);
    end
    idle(2 * BIT);

    // Reset during bit 4 abandons the frame
    fork
      send_frame(8'h5A, 1'b1, BIT);
      begin
        repeat (5 * BIT + H) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midreset_rdata", int'(rdata), 0);
        chk("midreset_valid", int'(rx_valid), 0);
        chk("midreset_ferr", int'(ferr), 0);
        chk("midreset_overrun", int'(overrun), 0);
      end
    join
    @(negedge clk);
    rstn = 1'b1;
    idle(2 * BIT);
    chk("post_reset_no_valid", int'(rx_valid), 0);
    push(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, BIT);
    idle(BIT);

    for (int i = 0; i < 20 * BIT && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
